// File: rtl/taxi_wrr_sched.sv
// taxi_wrr_sched - weighted round-robin packet scheduler.
//
// Grants one requester at a time for a tenure of up to weight[i] packets
// (a weight of 0 counts as 1). Once a packet has started, the grant is held
// until that packet ends. When a tenure ends and another requester is waiting,
// the next grant follows with no idle cycle in between.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   req            per-port request, level-sensitive
//   weight         packets per tenure, port i at [i*WEIGHT_W +: WEIGHT_W]
//   ack, last      beat accepted on the granted port / beat ends a packet
//   grant_valid    a grant is active
//   grant          one-hot grant (zero when idle)
//   grant_index    index of the granted port (zero when idle)
//   credit         packets remaining in the current tenure (zero when idle)
//   stat_pkt_count per-port 16-bit saturating count of completed packets
//                  (present only with TAXI_WRR_SCHED_STATS_EN defined)
//
// Optional feature macro: TAXI_WRR_SCHED_STATS_EN
//
// state | meaning
// ------+--------------------------------------------
// IDLE  | no grant outstanding
// GRANT | tenure active for port grant_index_q

module taxi_wrr_sched #(
    parameter int PORTS         = 4,
    parameter int WEIGHT_W      = 4,
    parameter int LSB_HIGH_PRIO = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS-1:0]            req,
    input  logic [PORTS*WEIGHT_W-1:0]   weight,
    input  logic                        ack,
    input  logic                        last,
    output logic                        grant_valid,
    output logic [PORTS-1:0]            grant,
    output logic [$clog2(PORTS)-1:0]    grant_index,
`ifdef TAXI_WRR_SCHED_STATS_EN
    output logic [PORTS*16-1:0]         stat_pkt_count,
`endif
    output logic [WEIGHT_W-1:0]         credit
);

    localparam int IDX_W = $clog2(PORTS);

    // Reset value of the last-served index, chosen so that the first
    // selection after reset lands on the highest-priority port.
    localparam logic [IDX_W-1:0] LAST_RST = (LSB_HIGH_PRIO != 0) ?
        IDX_W'(PORTS - 1) : '0;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                state_q;
    logic                  grant_valid_q;
    logic [PORTS-1:0]      grant_q;
    logic [IDX_W-1:0]      grant_index_q;
    logic [WEIGHT_W-1:0]   credit_q;
    logic                  pkt_active_q;
    logic [IDX_W-1:0]      last_q;

    logic                  sel_valid;
    logic [IDX_W-1:0]      sel_idx;
    logic [WEIGHT_W-1:0]   sel_weight;
    logic [WEIGHT_W-1:0]   sel_credit;
    logic [PORTS-1:0]      sel_onehot;
    logic                  cur_req;
    logic                  pkt_end;
    logic                  release_now;
    int                    cand;

    // Round-robin pick: nearest requester strictly after last_q in rotation
    // order; offset PORTS wraps back to last_q itself, so the previously
    // served port wins only when nobody else is asking.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = last_q;
        cand      = 0;
        for (int off = 1; off <= PORTS; off++) begin
            if (LSB_HIGH_PRIO != 0) begin
                cand = (int'(last_q) + off) % PORTS;
            end else begin
                cand = (int'(last_q) - off + PORTS) % PORTS;
            end
            if (!sel_valid && req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        sel_weight = weight[int'(sel_idx)*WEIGHT_W +: WEIGHT_W];
        sel_credit = (sel_weight == '0) ? WEIGHT_W'(1) : sel_weight;
        sel_onehot = PORTS'(1) << sel_idx;
    end

    assign cur_req = req[grant_index_q];
    assign pkt_end = ack && last;

    // An open packet blocks release unless this very beat closes it; every
    // release term either ends the packet or requires no packet open.
    assign release_now = (state_q == GRANT) &&
        ((pkt_end && (credit_q == WEIGHT_W'(1))) ||
         (pkt_end && !cur_req) ||
         (!pkt_active_q && !ack && !cur_req));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_q       <= '0;
            grant_index_q <= '0;
            credit_q      <= '0;
            pkt_active_q  <= 1'b0;
            last_q        <= LAST_RST;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_valid) begin
                        state_q       <= GRANT;
                        grant_valid_q <= 1'b1;
                        grant_q       <= sel_onehot;
                        grant_index_q <= sel_idx;
                        credit_q      <= sel_credit;
                        last_q        <= sel_idx;
                    end
                    pkt_active_q <= 1'b0;
                end
                GRANT: begin
                    if (release_now) begin
                        pkt_active_q <= 1'b0;
                        if (sel_valid) begin
                            grant_q       <= sel_onehot;
                            grant_index_q <= sel_idx;
                            credit_q      <= sel_credit;
                            last_q        <= sel_idx;
                        end else begin
                            state_q       <= IDLE;
                            grant_valid_q <= 1'b0;
                            grant_q       <= '0;
                            grant_index_q <= '0;
                            credit_q      <= '0;
                        end
                    end else if (pkt_end) begin
                        // credit_q > 1 here, otherwise this would be a release.
                        credit_q     <= credit_q - WEIGHT_W'(1);
                        pkt_active_q <= 1'b0;
                    end else if (ack) begin
                        pkt_active_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant       = grant_q;
    assign grant_index = grant_index_q;
    assign credit      = credit_q;

`ifdef TAXI_WRR_SCHED_STATS_EN
    logic [15:0] stat_q [PORTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < PORTS; p++) begin
                stat_q[p] <= '0;
            end
        end else if ((state_q == GRANT) && pkt_end &&
                     (stat_q[grant_index_q] != 16'hFFFF)) begin
            stat_q[grant_index_q] <= stat_q[grant_index_q] + 16'd1;
        end
    end

    for (genvar gp = 0; gp < PORTS; gp++) begin : g_stat
        assign stat_pkt_count[gp*16 +: 16] = stat_q[gp];
    end
`endif

endmodule
